trng_harvester: RTL and testbench

Harvests entropy from the free-running LUT ring oscillator built around the delay line. Its output is an asynchronous square wave. The block samples it in the `clk` domain, removes bias with a von Neumann extractor, packs the bits into words and presents them on a valid/ready port. It also runs a repetition-count health test and latches a sticky fault.

---
 rtl/sync2.sv | 23 ++
 rtl/trng_harvester.sv | 115 +++++++++++
 tb/tb_trng_harvester.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/sync2.sv
// Two-flop synchronizer for a single asynchronous input bit.
// Reusable for any async level or square-wave input that needs to enter the clk domain.
module sync2 (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  // NOTE: sequential state uses non-blocking assignments so both flops update from pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/trng_harvester.sv
// Ring-oscillator entropy harvester: sync, decimate, von Neumann debias, pack to words,
// valid/ready output, and a sticky repetition-count health test.
module trng_harvester #(
  parameter int WIDTH     = 8,
  parameter int DECIM     = 4,
  parameter int REP_LIMIT = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             osc_in,
  input  logic             enable,
  output logic [WIDTH-1:0] rnd_data,
  output logic             rnd_valid,
  input  logic             rnd_ready,
  output logic             health_fail
);

  localparam int DW = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam int BW = $clog2(WIDTH + 1);
  localparam int RW = $clog2(REP_LIMIT + 1);
  localparam logic [DW-1:0] DLAST = DW'(DECIM - 1);
  localparam logic [BW-1:0] BFULL = BW'(WIDTH);
  localparam logic [RW-1:0] RMAX  = RW'(REP_LIMIT);

  logic             s;
  logic [DW-1:0]    dcnt;
  logic             stb;
  logic             have_first;
  logic             first;
  logic             emit;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] shifted;
  logic [BW-1:0]    bcnt;
  logic             full;
  logic             load;
  logic [RW-1:0]    rep;
  logic [RW-1:0]    rep_next;
  logic             prev;
  logic             fail_now;

  // The oscillator enters the clk domain only through this synchronizer.
  sync2 u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (osc_in),
    .q     (s)
  );

  assign stb      = enable && (dcnt == DLAST);
  assign emit     = stb && have_first && (first != s);
  assign shifted  = {shreg[WIDTH-2:0], first};
  assign full     = (bcnt == BFULL);
  assign fail_now = stb && (rep_next == RMAX);
  assign load     = full && (!rnd_valid || rnd_ready) && !health_fail && !fail_now;

  // rep == 0 marks "no previous sample yet" (after reset or while disabled).
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    rep_next = rep;
    if (stb) begin
      if (rep == '0 || s != prev) rep_next = RW'(1);
      else if (rep != RMAX)       rep_next = rep + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      dcnt        <= '0;
      have_first  <= 1'b0;
      first       <= 1'b0;
      rep         <= '0;
      prev        <= 1'b0;
      shreg       <= '0;
      bcnt        <= '0;
      rnd_data    <= '0;
      rnd_valid   <= 1'b0;
      health_fail <= 1'b0;
    end else begin
      if (!enable) begin
        dcnt       <= '0;
        have_first <= 1'b0;
        rep        <= '0;
      end else begin
        dcnt <= (dcnt == DLAST) ? '0 : dcnt + 1'b1;
        rep  <= rep_next;
        if (stb) begin
          prev       <= s;
          have_first <= !have_first;
          if (!have_first) first <= s;
        end
      end

      // A bit emitted in the load cycle starts the next word instead of being lost.
      if (load) begin
        rnd_data <= shreg;
        if (emit) begin
          shreg <= shifted;
          bcnt  <= BW'(1);
        end else begin
          bcnt <= '0;
        end
      end else if (emit && !full) begin
        shreg <= shifted;
        bcnt  <= bcnt + 1'b1;
      end

      if (health_fail || fail_now) rnd_valid <= 1'b0;
      else if (load)               rnd_valid <= 1'b1;
      else if (rnd_ready)          rnd_valid <= 1'b0;

      if (fail_now) health_fail <= 1'b1;
    end
  end

endmodule

// File: tb/tb_trng_harvester.sv
// Directed bench for trng_harvester (DECIM=1, WIDTH=8, REP_LIMIT=32); inputs change and
// outputs are sampled on the falling clock edge.
module tb_trng_harvester;

  logic       clk;
  logic       reset;
  logic       osc_in;
  logic       enable;
  logic [7:0] rnd_data;
  logic       rnd_valid;
  logic       rnd_ready;
  logic       health_fail;

  int total  = 0;
  int passed = 0;
  int failed = 0;

  trng_harvester #(.WIDTH(8), .DECIM(1), .REP_LIMIT(32)) dut (
    .clk         (clk),
    .reset       (reset),
    .osc_in      (osc_in),
    .enable      (enable),
    .rnd_data    (rnd_data),
    .rnd_valid   (rnd_valid),
    .rnd_ready   (rnd_ready),
    .health_fail (health_fail)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock with osc_in = o across the rising edge; returns at the next falling edge.
  task automatic cyc(input logic o);
    osc_in = o;
    @(negedge clk);
  endtask

  // Each bit b becomes the raw pair (b, !b) followed by a 00 pad pair.
  task automatic send_bits(input logic [7:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      cyc(bits[i]);
      cyc(!bits[i]);
      cyc(1'b0);
      cyc(1'b0);
    end
  endtask

  task automatic idle(input int n);
    enable = 1'b0;
    for (int i = 0; i < n; i++) cyc(1'b0);
  endtask

  initial begin
    reset     = 1'b1;
    osc_in    = 1'b0;
    enable    = 1'b0;
    rnd_ready = 1'b0;
    @(negedge clk);
    cyc(1'b0);
    cyc(1'b0);
    check("rst_data",   rnd_data,    0);
    check("rst_valid",  rnd_valid,   0);
    check("rst_health", health_fail, 0);
    reset = 1'b0;
    idle(3);

    // Basic word: bits 1,0,1,1,0,0,1,0 -> 8'hB2
    rnd_ready = 1'b1;
    enable    = 1'b1;
    send_bits(8'hB2, 8);
    check("basic_pre_valid", rnd_valid, 0);
    cyc(1'b0);
    check("basic_valid", rnd_valid, 1);
    check("basic_data",  rnd_data,  8'hB2);
    cyc(1'b0);
    check("basic_drop_valid", rnd_valid, 0);
    idle(3);

    // Backpressure: 24 valid 10 pairs interleaved with 00/11 discard pairs, ready low
    rnd_ready = 1'b0;
    enable    = 1'b1;
    for (int i = 0; i < 24; i++) begin
      cyc(1'b1);
      cyc(1'b0);
      cyc(i[0]);
      cyc(i[0]);
      if (i == 11) begin
        check("bp_mid_valid", rnd_valid, 1);
        check("bp_mid_data",  rnd_data,  8'hFF);
      end
    end
    for (int i = 0; i < 4; i++) cyc(1'b0);
    check("bp_end_valid", rnd_valid, 1);
    check("bp_end_data",  rnd_data,  8'hFF);
    rnd_ready = 1'b1;
    cyc(1'b0);
    check("bp_xfer1_valid", rnd_valid, 1);
    check("bp_xfer1_data",  rnd_data,  8'hFF);
    cyc(1'b0);
    check("bp_xfer2_valid", rnd_valid, 0);
    cyc(1'b0);
    check("bp_third_dropped", rnd_valid, 0);
    idle(3);

    // Enable gating: 3 bits (101), pause mid-pair with toggling osc, then 5 bits (11001)
    enable = 1'b1;
    send_bits(8'b101, 3);
    cyc(1'b0);
    enable = 1'b0;
    for (int i = 0; i < 48; i++) cyc(i[0]);
    cyc(1'b0);
    cyc(1'b0);
    check("gate_pause_valid", rnd_valid, 0);
    check("gate_pause_data",  rnd_data,  8'hFF);
    enable = 1'b1;
    send_bits(8'b11001, 5);
    check("gate_pre_valid", rnd_valid, 0);
    cyc(1'b0);
    check("gate_valid", rnd_valid, 1);
    check("gate_data",  rnd_data,  8'hB9);
    cyc(1'b0);
    idle(3);

    // Reset mid-operation: word A5 held, 5 more bits pending
    rnd_ready = 1'b0;
    enable    = 1'b1;
    send_bits(8'hA5, 8);
    send_bits(8'h1F, 5);
    check("rmid_valid", rnd_valid, 1);
    check("rmid_data",  rnd_data,  8'hA5);
    reset  = 1'b1;
    enable = 1'b0;
    cyc(1'b0);
    reset = 1'b0;
    check("rmid_rst_data",   rnd_data,    0);
    check("rmid_rst_valid",  rnd_valid,   0);
    check("rmid_rst_health", health_fail, 0);
    rnd_ready = 1'b1;
    enable    = 1'b1;
    send_bits(8'h3C, 8);
    check("rmid_pre_valid", rnd_valid, 0);
    cyc(1'b0);
    check("rmid_new_valid", rnd_valid, 1);
    check("rmid_new_data",  rnd_data,  8'h3C);
    cyc(1'b0);
    idle(3);

    // Health test: word 5A held, then osc stuck at 1 for 32 samples
    rnd_ready = 1'b0;
    enable    = 1'b1;
    send_bits(8'h5A, 8);
    for (int i = 0; i < 33; i++) cyc(1'b1);
    check("hlt_31_health", health_fail, 0);
    check("hlt_31_valid",  rnd_valid,   1);
    check("hlt_31_data",   rnd_data,    8'h5A);
    cyc(1'b1);
    check("hlt_32_health", health_fail, 1);
    check("hlt_32_valid",  rnd_valid,   0);
    send_bits(8'hC3, 8);
    for (int i = 0; i < 3; i++) cyc(1'b0);
    rnd_ready = 1'b1;
    cyc(1'b0);
    check("hlt_after_valid",  rnd_valid,   0);
    check("hlt_after_health", health_fail, 1);
    reset  = 1'b1;
    enable = 1'b0;
    cyc(1'b0);
    reset = 1'b0;
    check("hlt_clear_health", health_fail, 0);
    check("hlt_clear_valid",  rnd_valid,   0);
    idle(2);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
